// File: rtl/mab_seq_mux.sv
`default_nettype none
// ============================================================================
//  Module   : mab_seq_mux
//  Brief    : Registered memory-address-bus source selector with wait-state
//             sequencing, auto-increment and access-complete handshake.
//             Optional build macro MAB_WORD_ALIGN_EN forces word alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module mab_seq_mux #(
    parameter int               WIDTH      = 16,
    parameter int               NSRC       = 5,
    parameter int               WAIT_CYC   = 0,
    parameter int               INC_STEP   = 2,
    parameter logic [WIDTH-1:0] RESET_ADDR = 16'hFFFE,
    localparam int              SELW       = $clog2(NSRC)
) (
    input  logic                  MCLK,
    input  logic                  RST_n,
    input  logic [NSRC*WIDTH-1:0] SRC_FLAT,
    input  logic [SELW-1:0]       MAB_SEL,
    input  logic                  MAB_REQ,
    input  logic                  MAB_INC,
    input  logic                  MEM_RDY,
    output logic [WIDTH-1:0]      MAB_out,
    output logic                  MAB_VALID,
    output logic                  MAB_BUSY,
    output logic                  MAB_ACK,
    output logic                  MAB_ERR
);

    localparam int               c_nslot    = 1 << SELW;
    localparam logic [SELW:0]    c_nsrc     = (SELW+1)'(NSRC);
    localparam logic [WIDTH-1:0] c_inc      = WIDTH'(INC_STEP);
    localparam logic [3:0]       c_wait_cyc = 4'(WAIT_CYC);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_ready = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_addr;
    logic             r_err;

    logic [WIDTH-1:0] w_src [c_nslot];
    logic [WIDTH-1:0] w_sel_src;
    logic [WIDTH-1:0] w_raw_addr;
    logic [WIDTH-1:0] w_next_addr;
    logic             w_sel_ok;
    logic             w_misalign;
    logic             w_ack;
    logic             w_open;
    logic             w_accept;
    logic             w_err;

    // Unused select codes map to zero so the mux never indexes out of range.
    generate
        for (genvar gi = 0; gi < c_nslot; gi++) begin : g_src
            if (gi < NSRC) begin : g_used
                assign w_src[gi] = SRC_FLAT[WIDTH*gi +: WIDTH];
            end else begin : g_pad
                assign w_src[gi] = '0;
            end
        end
    endgenerate

    assign w_sel_ok   = ({1'b0, MAB_SEL} < c_nsrc);
    assign w_sel_src  = w_src[MAB_SEL];
    assign w_raw_addr = MAB_REQ ? w_sel_src : (r_addr + c_inc);

`ifdef MAB_WORD_ALIGN_EN
    assign w_next_addr = {w_raw_addr[WIDTH-1:1], 1'b0};
    assign w_misalign  = MAB_REQ && w_sel_ok && w_sel_src[0];
`else
    assign w_next_addr = w_raw_addr;
    assign w_misalign  = 1'b0;
`endif

    // A new access may start when idle, or on the completing cycle of the current one.
    assign w_ack    = (r_state == c_st_ready) && MEM_RDY;
    assign w_open   = (r_state == c_st_idle) || w_ack;
    assign w_accept = w_open && (MAB_REQ ? w_sel_ok : MAB_INC);
    assign w_err    = w_open && ((MAB_REQ && !w_sel_ok) || w_misalign);

    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_addr  <= RESET_ADDR;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_accept) begin
                r_addr <= w_next_addr;
                if (c_wait_cyc != 4'd0) begin
                    r_state <= c_st_wait;
                    r_cnt   <= c_wait_cyc;
                end else begin
                    r_state <= c_st_ready;
                    r_cnt   <= 4'd0;
                end
            end else begin
                case (r_state)
                    c_st_wait: begin
                        if (r_cnt <= 4'd1) begin
                            r_state <= c_st_ready;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    c_st_ready: begin
                        if (MEM_RDY) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign MAB_out   = r_addr;
    assign MAB_VALID = (r_state != c_st_idle);
    assign MAB_ACK   = w_ack;
    assign MAB_BUSY  = (r_state != c_st_idle) && !w_ack;
    assign MAB_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mab_seq_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mab_seq_mux
//  Brief    : Directed and randomized bench for mab_seq_mux (no-wait and
//             two-wait-state instances driven from the same inputs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mab_seq_mux;

`ifdef MAB_WORD_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mab_req;
    logic        mab_inc;
    logic        mem_rdy;
    logic [2:0]  mab_sel;
    logic [15:0] src [8];
    logic [79:0] src_flat;

    logic [15:0] d_out   [2];
    logic        d_valid [2];
    logic        d_busy  [2];
    logic        d_ack   [2];
    logic        d_err   [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign src_flat = {src[4], src[3], src[2], src[1], src[0]};

    mab_seq_mux #(.WIDTH(16), .NSRC(5), .WAIT_CYC(0), .INC_STEP(2), .RESET_ADDR(16'hFFFE)) u_dut0 (
        .MCLK(clk), .RST_n(rst_n), .SRC_FLAT(src_flat), .MAB_SEL(mab_sel),
        .MAB_REQ(mab_req), .MAB_INC(mab_inc), .MEM_RDY(mem_rdy),
        .MAB_out(d_out[0]), .MAB_VALID(d_valid[0]), .MAB_BUSY(d_busy[0]),
        .MAB_ACK(d_ack[0]), .MAB_ERR(d_err[0])
    );

    mab_seq_mux #(.WIDTH(16), .NSRC(5), .WAIT_CYC(2), .INC_STEP(2), .RESET_ADDR(16'hFFFE)) u_dut2 (
        .MCLK(clk), .RST_n(rst_n), .SRC_FLAT(src_flat), .MAB_SEL(mab_sel),
        .MAB_REQ(mab_req), .MAB_INC(mab_inc), .MEM_RDY(mem_rdy),
        .MAB_out(d_out[1]), .MAB_VALID(d_valid[1]), .MAB_BUSY(d_busy[1]),
        .MAB_ACK(d_ack[1]), .MAB_ERR(d_err[1])
    );

    // Reference model: an access is "active" with a count of wait cycles left.
    logic [15:0] m_addr   [2];
    logic        m_active [2];
    int          m_wait   [2];
    logic        m_err    [2];

    function automatic int wcyc(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic f_ack(int k);
        return m_active[k] && (m_wait[k] == 0) && mem_rdy;
    endfunction

    function automatic logic f_can(int k);
        return !m_active[k] || f_ack(k);
    endfunction

    function automatic logic f_accept(int k);
        if (!f_can(k)) return 1'b0;
        if (mab_req) return (mab_sel < 3'd5);
        return mab_inc;
    endfunction

    function automatic logic f_err(int k);
        logic bad;
        bad = (mab_sel >= 3'd5) || (ALIGN && src[mab_sel][0]);
        return f_can(k) && mab_req && bad;
    endfunction

    function automatic logic [15:0] f_load(int k);
        logic [15:0] a;
        a = mab_req ? src[mab_sel] : (m_addr[k] + 16'd2);
        if (ALIGN) a[0] = 1'b0;
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_addr[k]   <= 16'hFFFE;
                m_active[k] <= 1'b0;
                m_wait[k]   <= 0;
                m_err[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_err[k] <= f_err(k);
                if (f_accept(k)) begin
                    m_addr[k]   <= f_load(k);
                    m_active[k] <= 1'b1;
                    m_wait[k]   <= wcyc(k);
                end else if (f_ack(k)) begin
                    m_active[k] <= 1'b0;
                end else if (m_active[k] && m_wait[k] > 0) begin
                    m_wait[k] <= m_wait[k] - 1;
                end
            end
        end
    end

    task automatic idle_all();
        @(negedge clk);
        mab_req = 1'b0;
        mab_inc = 1'b0;
        mem_rdy = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        src[2]  = 16'h0AB0;
        mab_req = 1'b1;
        mab_sel = 3'd2;
        mem_rdy = 1'b0;
        @(negedge clk);
        mem_rdy = 1'b1;
        rst_n   = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_out[k] !== 16'hFFFE) begin
                n_err++; $display("FAIL reset_out[%0d]: got %h want fffe", k, d_out[k]);
            end
            n_vec++;
            if (d_valid[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", k, d_valid[k]);
            end
            n_vec++;
            if (d_busy[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", k, d_busy[k]);
            end
            n_vec++;
            if (d_ack[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_ack[%0d]: got %b want 0", k, d_ack[k]);
            end
            n_vec++;
            if (d_err[k] !== 1'b0) begin
                n_err++; $display("FAIL reset_err[%0d]: got %b want 0", k, d_err[k]);
            end
        end
        @(negedge clk);
        mab_req = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        mab_inc = 1'b1;
        mem_rdy = 1'b1;
        @(negedge clk);
        mab_inc = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_out[k] !== 16'h0000) begin
                n_err++; $display("FAIL wrap_out[%0d]: got %h want 0000", k, d_out[k]);
            end
            n_vec++;
            if (d_valid[k] !== 1'b1) begin
                n_err++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, d_valid[k]);
            end
            n_vec++;
            if (d_err[k] !== 1'b0) begin
                n_err++; $display("FAIL wrap_err[%0d]: got %b want 0", k, d_err[k]);
            end
        end
    endtask

    task automatic test_single_nowait();
        @(negedge clk);
        src[2]  = 16'h1234;
        mab_req = 1'b1;
        mab_sel = 3'd2;
        mem_rdy = 1'b1;
        @(negedge clk);
        mab_req = 1'b0;
        #1;
        n_vec++;
        if (d_out[0] !== 16'h1234) begin
            n_err++; $display("FAIL nowait_out: got %h want 1234", d_out[0]);
        end
        n_vec++;
        if (d_valid[0] !== 1'b1 || d_ack[0] !== 1'b1 || d_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL nowait_hs: got v=%b a=%b b=%b want v=1 a=1 b=0",
                              d_valid[0], d_ack[0], d_busy[0]);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (d_valid[0] !== 1'b0 || d_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL nowait_idle: got v=%b b=%b want v=0 b=0", d_valid[0], d_busy[0]);
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        src[0]  = 16'hC000;
        mab_req = 1'b1;
        mab_sel = 3'd0;
        mem_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mab_req = 1'b0;
            mab_inc = 1'b1;
            mem_rdy = 1'b0;
            #1;
            n_vec++;
            if (d_busy[1] !== 1'b1 || d_ack[1] !== 1'b0) begin
                n_err++; $display("FAIL wait_busy c%0d: got b=%b a=%b want b=1 a=0", c, d_busy[1], d_ack[1]);
            end
            n_vec++;
            if (d_out[1] !== 16'hC000 || d_valid[1] !== 1'b1) begin
                n_err++; $display("FAIL wait_hold c%0d: got %h v=%b want c000 v=1", c, d_out[1], d_valid[1]);
            end
        end
        @(negedge clk);
        mab_inc = 1'b0;
        mem_rdy = 1'b1;
        #1;
        n_vec++;
        if (d_ack[1] !== 1'b1 || d_busy[1] !== 1'b0 || d_out[1] !== 16'hC000) begin
            n_err++; $display("FAIL wait_ack: got a=%b b=%b %h want a=1 b=0 c000", d_ack[1], d_busy[1], d_out[1]);
        end
    endtask

    task automatic test_bad_sel();
        @(negedge clk);
        mab_req = 1'b1;
        mab_sel = 3'd5;
        mem_rdy = 1'b1;
        @(negedge clk);
        mab_req = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_err[k] !== 1'b1) begin
                n_err++; $display("FAIL badsel_err[%0d]: got %b want 1", k, d_err[k]);
            end
            n_vec++;
            if (d_out[k] !== 16'hC000 || d_valid[k] !== 1'b0) begin
                n_err++; $display("FAIL badsel_hold[%0d]: got %h v=%b want c000 v=0", k, d_out[k], d_valid[k]);
            end
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_err[k] !== 1'b0) begin
                n_err++; $display("FAIL badsel_pulse[%0d]: got %b want 0", k, d_err[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        src[0]  = 16'h0100;
        src[1]  = ALIGN ? 16'h0201 : 16'h0200;
        mab_req = 1'b1;
        mab_sel = 3'd0;
        mem_rdy = 1'b1;
        @(negedge clk);
        mab_sel = 3'd1;
        #1;
        n_vec++;
        if (d_ack[0] !== 1'b1 || d_out[0] !== 16'h0100) begin
            n_err++; $display("FAIL b2b_first: got a=%b %h want a=1 0100", d_ack[0], d_out[0]);
        end
        @(negedge clk);
        mab_req = 1'b0;
        #1;
        n_vec++;
        if (d_out[0] !== 16'h0200 || d_valid[0] !== 1'b1) begin
            n_err++; $display("FAIL b2b_second: got %h v=%b want 0200 v=1", d_out[0], d_valid[0]);
        end
        n_vec++;
        if (d_err[0] !== ALIGN) begin
            n_err++; $display("FAIL b2b_err: got %b want %b", d_err[0], ALIGN);
        end
        n_vec++;
        if (d_out[1] !== 16'h0100) begin
            n_err++; $display("FAIL b2b_wait_ignore: got %h want 0100", d_out[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 99) != 0);
            mab_req = ($urandom_range(0, 3) == 0);
            mab_inc = ($urandom_range(0, 3) == 0);
            mab_sel = 3'($urandom_range(0, 7));
            mem_rdy = 1'($urandom_range(0, 1));
            for (int i = 0; i < 5; i++) src[i] = 16'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (d_out[k] !== m_addr[k]) begin
                    n_err++; $display("FAIL rnd_out[%0d] n%0d: got %h want %h", k, n, d_out[k], m_addr[k]);
                end
                n_vec++;
                if (d_valid[k] !== m_active[k]) begin
                    n_err++; $display("FAIL rnd_valid[%0d] n%0d: got %b want %b", k, n, d_valid[k], m_active[k]);
                end
                n_vec++;
                if (d_ack[k] !== (rst_n && f_ack(k))) begin
                    n_err++; $display("FAIL rnd_ack[%0d] n%0d: got %b want %b", k, n, d_ack[k], rst_n && f_ack(k));
                end
                n_vec++;
                if (d_busy[k] !== (m_active[k] && !f_ack(k))) begin
                    n_err++; $display("FAIL rnd_busy[%0d] n%0d: got %b want %b", k, n, d_busy[k],
                                      m_active[k] && !f_ack(k));
                end
                n_vec++;
                if (d_err[k] !== m_err[k]) begin
                    n_err++; $display("FAIL rnd_err[%0d] n%0d: got %b want %b", k, n, d_err[k], m_err[k]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        mab_req = 1'b0;
        mab_inc = 1'b0;
        mem_rdy = 1'b0;
        mab_sel = 3'd0;
        for (int i = 0; i < 8; i++) src[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_wrap();
        idle_all();
        test_single_nowait();
        idle_all();
        test_wait_states();
        idle_all();
        test_bad_sel();
        test_back_to_back();
        idle_all();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
